muldiv_sequencer_32b: RTL and testbench
=======================================

# muldiv_sequencer_32b

Multi-cycle unsigned multiply/divide controller that time-shares one external 32-bit Kogge-Stone adder/subtractor instead of instantiating a dedicated multiplier or divider. It accepts one operation at a time and runs a shift-add multiply or a restoring divide, one adder pass per cycle. It returns a 64-bit product, or a quotient and remainder. It sits beside the ALU in the CPU execute stage; its adder-port outputs connect directly to the adder instance's a, b and s inputs.

## Interface
- No parameters; the datapath width is fixed at 32 bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  1  0 = MULU, 1 = DIVU
- opa  in  32  multiplicand (MULU) / dividend (DIVU)
- opb  in  32  multiplier (MULU) / divisor (DIVU)
- busy  out  1  high in CALC and DONE
- done  out  1  one-cycle pulse; the result is valid from this cycle on
- result_lo  out  32  product[31:0] / quotient
- result_hi  out  32  product[63:32] / remainder
- add_a  out  32  adder operand a
- add_b  out  32  adder operand b (before the adder's internal inversion)
- add_s  out  1  adder mode: 0 = add, 1 = subtract
- add_sum  in  32  adder sum; combinational return in the same cycle
- add_cout  in  1  adder carry out; in subtract mode, 1 = no borrow

## Operation
- **States:** IDLE, CALC, DONE. Internal registers: hi/rem (32), lo/quo (32), opnd (32), cnt (5), op_r.
- **IDLE with start=1:**
  - Latch op_r=op and opnd.
  - MULU: opnd=opa, hi=0, lo=opb.
  - DIVU: opnd=opb, rem=0, quo=opa.
  - Set cnt=0 and go to CALC.
  - DIVU with opb==0: skip CALC. Load quo=32'hFFFF_FFFF and rem=opa, then go directly to DONE.
- **IDLE with start=0:** hold all state.
- **CALC, MULU (each cycle):**
  - Drive add_a=hi, add_b = lo[0] ? opnd : 0, add_s=0.
  - Update {hi,lo} <= {add_cout, add_sum, lo[31:1]}.
- **CALC, DIVU (each cycle):**
  - Form sh={rem[30:0], quo[31]}.
  - Drive add_a=sh, add_b=opnd, add_s=1.
  - Compute take = rem[31] | add_cout.
  - Update rem <= take ? add_sum : sh, and quo <= {quo[30:0], take}.
- **CALC exit:** cnt increments every CALC cycle. The cycle with cnt==31 transitions to DONE.
- **DONE:** done=1 for exactly this cycle, then go to IDLE. No adder use.
- **Result outputs:** result_lo/result_hi drive the lo/quo and hi/rem registers. They are stable from DONE until the next accepted start.
- **Adder ports outside CALC:** add_a=0, add_b=0, add_s=0.
- **start while busy:** ignored. It is not queued and has no effect on the running operation.
- **Operand sampling:** opa/opb/op are sampled only in the cycle start is accepted. Later changes have no effect.

## Timing
- **Reset values:** asynchronous assertion of rst_n clears everything immediately, mid-operation included.
  - state=IDLE.
  - busy=0, done=0.
  - result_lo=0, result_hi=0.
  - add_a=0, add_b=0, add_s=0.
  - cnt=0.
  - An aborted operation produces no done.
- **Normal latency:** start accepted at edge T. CALC occupies cycles T+1..T+32. done is high in cycle T+33. IDLE at T+34; a new start is accepted at edge T+34 at the earliest.
- **Divide-by-zero latency:** start accepted at T, done high in cycle T+1, IDLE at T+2.
- **busy:** high from the cycle after acceptance through the DONE cycle inclusive.
- **Adder path:** add_sum/add_cout are used combinationally within a single cycle. The adder path plus the register update must close timing in one clk period.
- **Throughput:** at most one operation per 34 cycles (2 for divide-by-zero).

## Test plan
- **MULU small:** opa=7, opb=6 -> at T+33 done=1, result_hi=0, result_lo=42. busy high T+1..T+33.
- **MULU max:** opa=opb=32'hFFFF_FFFF -> result_hi=32'hFFFF_FFFE, result_lo=32'h0000_0001. Exercises add_cout shifting into hi.
- **DIVU:**
  - 100/7 -> result_lo=14, result_hi=2.
  - 32'hFFFF_FFFF/32'h8000_0001 -> result_lo=1, result_hi=32'h7FFF_FFFE. Exercises the rem[31] take path.
- **DIVU by zero:** opa=32'h1234, opb=0 -> done at T+1, result_lo=32'hFFFF_FFFF, result_hi=32'h1234. add_s never asserted.
- **start while busy:** start MULU 3×5, pulse start with op=1, opa=9, opb=3 at T+10 -> ignored. done only at T+33 with result_lo=15. Next start accepted at T+34.
- **Reset mid-operation:** drop rst_n at T+12 during DIVU -> busy, done, result_* and add_* read 0 in the same cycle without a clock edge. After release, no done. A fresh 100/7 gives 14 r 2.

Source files
------------

// File: rtl/muldiv_sequencer_32b_if.sv
// Request, result and shared-adder signals between the execute stage and the multiply/divide sequencer.
// The master side issues requests and hosts the adder; the slave side is the sequencer.
interface muldiv_sequencer_32b_if;
  logic        start;
  logic        op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_s;
  logic [31:0] add_sum;
  logic        add_cout;

  modport master (
    output start, op, opa, opb, add_sum, add_cout,
    input  busy, done, result_lo, result_hi, add_a, add_b, add_s
  );

  modport slave (
    input  start, op, opa, opb, add_sum, add_cout,
    output busy, done, result_lo, result_hi, add_a, add_b, add_s
  );
endinterface

// File: rtl/muldiv_sequencer_32b.sv
// Unsigned shift-add multiply / restoring divide on a shared external adder; done 33 cycles after accept (1 for divide by zero).
// No backpressure: start is taken only in IDLE and ignored while busy.
module muldiv_sequencer_32b (
  input  logic                        clk,
  input  logic                        rst_n,
  muldiv_sequencer_32b_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] opnd;
  logic [4:0]  cnt;
  logic        op_r;
  logic        busy_q;
  logic        done_q;

  // Divide step: remainder shifted left with the next dividend bit.
  logic [31:0] sh;
  logic        take;
  assign sh   = {hi[30:0], lo[31]};
  assign take = hi[31] | bus.add_cout;

  always_comb begin
    bus.add_a = 32'd0;
    bus.add_b = 32'd0;
    bus.add_s = 1'b0;
    if (state == CALC) begin
      if (op_r) begin
        bus.add_a = sh;
        bus.add_b = opnd;
        bus.add_s = 1'b1;
      end else begin
        bus.add_a = hi;
        bus.add_b = lo[0] ? opnd : 32'd0;
        bus.add_s = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      hi     <= 32'd0;
      lo     <= 32'd0;
      opnd   <= 32'd0;
      cnt    <= 5'd0;
      op_r   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_r   <= bus.op;
            cnt    <= 5'd0;
            busy_q <= 1'b1;
            if (bus.op && (bus.opb == 32'd0)) begin
              opnd   <= bus.opb;
              hi     <= bus.opa;
              lo     <= 32'hFFFF_FFFF;
              done_q <= 1'b1;
              state  <= DONE;
            end else if (bus.op) begin
              opnd  <= bus.opb;
              hi    <= 32'd0;
              lo    <= bus.opa;
              state <= CALC;
            end else begin
              opnd  <= bus.opa;
              hi    <= 32'd0;
              lo    <= bus.opb;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (op_r) begin
            hi <= take ? bus.add_sum : sh;
            lo <= {lo[30:0], take};
          end else begin
            hi <= {bus.add_cout, bus.add_sum[31:1]};
            lo <= {bus.add_sum[0], lo[31:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result_lo = lo;
  assign bus.result_hi = hi;

endmodule

// File: tb/tb_muldiv_sequencer_32b.sv
// Directed vector bench for muldiv_sequencer_32b with a behavioural model of the shared adder.
module tb_muldiv_sequencer_32b;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  muldiv_sequencer_32b_if bus ();

  muldiv_sequencer_32b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Adder: subtract is a + ~b + 1, carry out 1 means no borrow.
  logic [32:0] add_res;
  assign add_res      = {1'b0, bus.add_a} + {1'b0, (bus.add_s ? ~bus.add_b : bus.add_b)} + {32'd0, bus.add_s};
  assign bus.add_sum  = add_res[31:0];
  assign bus.add_cout = add_res[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    int          exp_lat;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = ~op;
    bus.opa   = ~a;
    bus.opb   = ~b;
  endtask

  // Samples mid-cycle from the cycle after acceptance; lat = cycle index of done, -1 on timeout.
  task automatic wait_done(input int limit, output int lat, output bit busy_ok, output bit adds_seen);
    lat       = -1;
    busy_ok   = 1'b1;
    adds_seen = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (bus.add_s) adds_seen = 1'b1;
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int  lat;
    bit  busy_ok;
    bit  adds_seen;
    int  done_cnt;
    logic adds_before;

    n_cmp = 0;
    n_err = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.opa   = 32'd0;
    bus.opb   = 32'd0;

    vecs[0] = '{1'b0, 32'd7,          32'd6,          32'd42,         32'd0,          33};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32'hFFFF_FFFE,  33};
    vecs[2] = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          33};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  33};
    vecs[4] = '{1'b1, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1};
    vecs[5] = '{1'b0, 32'h0001_0000,  32'h0001_0000,  32'd0,          32'd1,          33};
    vecs[6] = '{1'b0, 32'h8000_0000,  32'd2,          32'd0,          32'd1,          33};
    vecs[7] = '{1'b1, 32'd5,          32'd9,          32'd0,          32'd5,          33};
    vecs[8] = '{1'b1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};

    #12;
    chk("reset_outputs", {bus.busy, bus.done, bus.result_lo, bus.result_hi},
        {2'b00, 32'd0, 32'd0});
    chk("reset_adder", {bus.add_a, bus.add_b, bus.add_s}, {65'd0});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_busy", {bus.busy, bus.done}, 2'b00);

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].opa, vecs[i].opb);
      wait_done(40, lat, busy_ok, adds_seen);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_result_lo", i), bus.result_lo, vecs[i].exp_lo);
      chk($sformatf("v%0d_result_hi", i), bus.result_hi, vecs[i].exp_hi);
      chk($sformatf("v%0d_busy_span", i), busy_ok, 1'b1);
      chk($sformatf("v%0d_add_s", i), adds_seen, (vecs[i].exp_lat == 33) ? vecs[i].op : 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_after_done", i), {bus.busy, bus.done, bus.add_a, bus.add_b, bus.add_s},
          {2'b00, 65'd0});
      chk($sformatf("v%0d_hold_lo", i), bus.result_lo, vecs[i].exp_lo);
    end

    // start while busy is ignored; next start accepted right after DONE
    issue(1'b0, 32'd3, 32'd5);
    repeat (10) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.opa   = 32'd9;
    bus.opb   = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(40, lat, busy_ok, adds_seen);
    chk("busy_start_latency", (lat < 0) ? lat : lat + 10, 33);
    chk("busy_start_result", {bus.result_hi, bus.result_lo}, {32'd0, 32'd15});
    chk("busy_start_mul_mode", adds_seen, 1'b0);
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.opa   = 32'd100;
    bus.opb   = 32'd7;
    @(posedge clk);
    @(negedge clk);
    chk("ignored_in_done", bus.busy, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("accepted_t34", bus.busy, 1'b1);
    wait_done(40, lat, busy_ok, adds_seen);
    chk("b2b_latency", lat, 32);
    chk("b2b_result", {bus.result_hi, bus.result_lo}, {32'd2, 32'd14});

    // asynchronous reset in the middle of a divide
    issue(1'b1, 32'd100, 32'd7);
    repeat (12) @(negedge clk);
    adds_before = bus.add_s;
    chk("pre_reset_calc", {bus.busy, adds_before}, 2'b11);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_ctl", {bus.busy, bus.done}, 2'b00);
    chk("async_reset_result", {bus.result_hi, bus.result_lo}, 64'd0);
    chk("async_reset_adder", {bus.add_a, bus.add_b, bus.add_s}, 65'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_cnt++;
    end
    chk("no_done_after_abort", done_cnt, 0);
    issue(1'b1, 32'd100, 32'd7);
    wait_done(40, lat, busy_ok, adds_seen);
    chk("post_reset_latency", lat, 33);
    chk("post_reset_result", {bus.result_hi, bus.result_lo}, {32'd2, 32'd14});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
